// File: rtl/store_buf.sv
// store_buf: in-order store buffer between the CPU write port and a
// single-port RAM. Stores are accepted in one cycle, retired to RAM only in
// cycles without a CPU load, and buffered bytes are merged into load data.
// Optional feature macro: STORE_BUF_PERF_EN (adds two 32-bit perf counters).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 64
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module store_buf #(
  parameter int DEPTH = 4
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_rst,
  input  logic                         i_cpu_wr_en,
  input  logic [`ADDR_WIDTH-1:0]       i_cpu_wr_addr,
  input  logic [`DATA_WIDTH-1:0]       i_cpu_wr_data,
  input  logic [`DATA_WIDTH/8-1:0]     i_cpu_wr_mask,
  output logic                         o_cpu_wr_rdy,
  input  logic                         i_cpu_rd_en,
  input  logic [`ADDR_WIDTH-1:0]       i_cpu_rd_addr,
  output logic [`DATA_WIDTH-1:0]       o_cpu_rd_data,
  output logic                         o_ram_rd_en,
  output logic [`ADDR_WIDTH-1:0]       o_ram_rd_addr,
  input  logic [`DATA_WIDTH-1:0]       i_ram_rd_data,
  output logic                         o_ram_wr_en,
  output logic [`ADDR_WIDTH-1:0]       o_ram_wr_addr,
  output logic [`DATA_WIDTH-1:0]       o_ram_wr_data,
  output logic [`DATA_WIDTH/8-1:0]     o_ram_wr_mask,
  input  logic                         i_flush,
  output logic                         o_buf_empty
`ifdef STORE_BUF_PERF_EN
  ,
  output logic [31:0]                  o_perf_full_cnt,
  output logic [31:0]                  o_perf_fwd_cnt
`endif
);

  localparam int AW    = `ADDR_WIDTH;
  localparam int DW    = `DATA_WIDTH;
  localparam int LANES = DW / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [DW-1:0]    data;
    logic [LANES-1:0] mask;
  } entry_t;

  // Storage and control state
  entry_t          entry_q [DEPTH];
  entry_t          entry_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Handshake / datapath helpers
  logic            full_s;
  logic            empty_s;
  logic            enq_s;
  logic            ret_s;
  logic [PW-1:0]   slot_s   [DEPTH];
  logic            valid_s  [DEPTH];
  logic [LANES-1:0] fwd_hit_s;
  logic [DW-1:0]   rd_data_s;

  // Occupancy flags and the accept/retire handshake decisions.
  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    // Reset suppresses retire in the reset cycle itself so no discarded
    // store can reach RAM.
    ret_s   = !empty_s && !i_cpu_rd_en && !i_sys_rst;
    enq_s   = i_cpu_wr_en && !full_s && !i_flush;
  end

  // Age-ordered view of the FIFO: slot 0 is the head (oldest entry).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_s[i]  = rd_ptr_q + PW'(i);
      valid_s[i] = (CW'(i) < count_q);
    end
  end

  // Next-state for pointers and occupancy; enqueue and retire may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (ret_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_s, ret_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Next-state for entry storage: only the tail slot is written on accept.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (enq_s) begin
      entry_d[wr_ptr_q] = '{addr: i_cpu_wr_addr,
                            data: i_cpu_wr_data,
                            mask: i_cpu_wr_mask};
    end else begin
      entry_d[wr_ptr_q] = entry_q[wr_ptr_q];
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by count so they need no reset.
  always_ff @(posedge i_sys_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

  // Load forwarding: walk entries oldest to newest so the newest match wins
  // per byte lane; lanes without a match keep the RAM byte.
  always_comb begin
    rd_data_s = i_ram_rd_data;
    fwd_hit_s = {LANES{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < LANES; b++) begin
        if (valid_s[i] &&
            (entry_q[slot_s[i]].addr[AW-1:OFS] == i_cpu_rd_addr[AW-1:OFS]) &&
            entry_q[slot_s[i]].mask[b]) begin
          rd_data_s[b*8 +: 8] = entry_q[slot_s[i]].data[b*8 +: 8];
          fwd_hit_s[b]        = 1'b1;
        end else begin
          rd_data_s[b*8 +: 8] = rd_data_s[b*8 +: 8];
          fwd_hit_s[b]        = fwd_hit_s[b];
        end
      end
    end
  end

  // Output drive: read pass-through, head entry on the retire port.
  always_comb begin
    o_cpu_wr_rdy  = !full_s && !i_flush;
    o_buf_empty   = empty_s;
    o_cpu_rd_data = rd_data_s;
    o_ram_rd_en   = i_cpu_rd_en;
    o_ram_rd_addr = i_cpu_rd_addr;
    o_ram_wr_en   = ret_s;
    o_ram_wr_addr = entry_q[rd_ptr_q].addr;
    o_ram_wr_data = entry_q[rd_ptr_q].data;
    o_ram_wr_mask = entry_q[rd_ptr_q].mask;
  end

`ifdef STORE_BUF_PERF_EN
  logic [31:0] perf_full_cnt_q, perf_full_cnt_d;
  logic [31:0] perf_fwd_cnt_q,  perf_fwd_cnt_d;

  // Performance counters: blocked store cycles and forwarded loads; both wrap.
  always_comb begin
    perf_full_cnt_d = perf_full_cnt_q;
    perf_fwd_cnt_d  = perf_fwd_cnt_q;
    if (i_cpu_wr_en && !o_cpu_wr_rdy) begin
      perf_full_cnt_d = perf_full_cnt_q + 32'd1;
    end else begin
      perf_full_cnt_d = perf_full_cnt_q;
    end
    if (i_cpu_rd_en && (|fwd_hit_s)) begin
      perf_fwd_cnt_d = perf_fwd_cnt_q + 32'd1;
    end else begin
      perf_fwd_cnt_d = perf_fwd_cnt_q;
    end
  end

  // Performance counter registers with synchronous reset.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      perf_full_cnt_q <= 32'd0;
      perf_fwd_cnt_q  <= 32'd0;
    end else begin
      perf_full_cnt_q <= perf_full_cnt_d;
      perf_fwd_cnt_q  <= perf_fwd_cnt_d;
    end
  end

  assign o_perf_full_cnt = perf_full_cnt_q;
  assign o_perf_fwd_cnt  = perf_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_store_buf.sv
// Directed self-checking bench for store_buf (64-bit address/data, DEPTH 4).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 64
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module tb_store_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [63:0] wr_addr = 64'd0;
  logic [63:0] wr_data = 64'd0;
  logic [7:0]  wr_mask = 8'd0;
  logic        wr_rdy;
  logic        rd_en = 1'b0;
  logic [63:0] rd_addr = 64'd0;
  logic [63:0] rd_data;
  logic        ram_rd_en;
  logic [63:0] ram_rd_addr;
  logic [63:0] ram_data = 64'd0;
  logic        ram_wr_en;
  logic [63:0] ram_wr_addr;
  logic [63:0] ram_wr_data;
  logic [7:0]  ram_wr_mask;
  logic        flush = 1'b0;
  logic        buf_empty;
`ifdef STORE_BUF_PERF_EN
  logic [31:0] perf_full;
  logic [31:0] perf_fwd;
`endif

  int total = 0;
  int bad   = 0;

  store_buf #(.DEPTH(4)) dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_cpu_wr_en   (wr_en),
    .i_cpu_wr_addr (wr_addr),
    .i_cpu_wr_data (wr_data),
    .i_cpu_wr_mask (wr_mask),
    .o_cpu_wr_rdy  (wr_rdy),
    .i_cpu_rd_en   (rd_en),
    .i_cpu_rd_addr (rd_addr),
    .o_cpu_rd_data (rd_data),
    .o_ram_rd_en   (ram_rd_en),
    .o_ram_rd_addr (ram_rd_addr),
    .i_ram_rd_data (ram_data),
    .o_ram_wr_en   (ram_wr_en),
    .o_ram_wr_addr (ram_wr_addr),
    .o_ram_wr_data (ram_wr_data),
    .o_ram_wr_mask (ram_wr_mask),
    .i_flush       (flush),
    .o_buf_empty   (buf_empty)
`ifdef STORE_BUF_PERF_EN
    ,
    .o_perf_full_cnt (perf_full),
    .o_perf_fwd_cnt  (perf_fwd)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_empty", 64'(buf_empty), 64'd1);
    chk("rst_wr_en", 64'(ram_wr_en), 64'd0);
    chk("rst_rdy",   64'(wr_rdy),    64'd1);
`ifdef STORE_BUF_PERF_EN
    chk("rst_perf_full", 64'(perf_full), 64'd0);
    chk("rst_perf_fwd",  64'(perf_fwd),  64'd0);
`endif

    // Basic store: retires the cycle after acceptance, no bypass
    store(64'h0000_0000_8000_0000, 64'h1122_3344_5566_7788, 8'hFF);
    settle();
    chk("basic_rdy",      64'(wr_rdy),    64'd1);
    chk("basic_no_bypass",64'(ram_wr_en), 64'd0);
    tick();
    wr_en = 1'b0;
    settle();
    chk("basic_wr_en",   64'(ram_wr_en),   64'd1);
    chk("basic_wr_addr", ram_wr_addr,      64'h0000_0000_8000_0000);
    chk("basic_wr_data", ram_wr_data,      64'h1122_3344_5566_7788);
    chk("basic_wr_mask", 64'(ram_wr_mask), 64'hFF);
    chk("basic_busy",    64'(buf_empty),   64'd0);
    tick();
    settle();
    chk("basic_done_wr_en", 64'(ram_wr_en), 64'd0);
    chk("basic_done_empty", 64'(buf_empty), 64'd1);

    // Back-pressure: loads starve retire, 5th store refused
    rd_en    = 1'b1;
    rd_addr  = 64'h0000_0000_0000_1000;
    ram_data = 64'd0;
    for (int i = 0; i < 4; i++) begin
      store(64'h100 + 64'(i * 8), 64'hA0 + 64'(i), 8'hFF);
      settle();
      chk("bp_rdy",      64'(wr_rdy),    64'd1);
      chk("bp_no_wr",    64'(ram_wr_en), 64'd0);
      chk("bp_ram_rd",   64'(ram_rd_en), 64'd1);
      tick();
    end
    store(64'h120, 64'hA4, 8'hFF);
    settle();
    chk("bp_full_rdy", 64'(wr_rdy),    64'd0);
    chk("bp_full_wr",  64'(ram_wr_en), 64'd0);
    chk("bp_rd_addr",  ram_rd_addr,    64'h1000);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("bp_ret_en",   64'(ram_wr_en), 64'd1);
      chk("bp_ret_addr", ram_wr_addr,    64'h100 + 64'(i * 8));
      chk("bp_ret_data", ram_wr_data,    64'hA0 + 64'(i));
      tick();
      settle();
    end
    chk("bp_empty", 64'(buf_empty), 64'd1);
    chk("bp_idle",  64'(ram_wr_en), 64'd0);

    // Byte-merge forwarding with retire held off by loads
    rd_en    = 1'b1;
    rd_addr  = 64'h2000;
    ram_data = 64'd0;
    store(64'h200, 64'h0000_0000_0000_00AA, 8'h01);
    tick();
    store(64'h200, 64'h0000_0000_0000_CCBB, 8'h03);
    tick();
    wr_en   = 1'b0;
    rd_addr = 64'h200;
    settle();
    chk("fwd_merge",  rd_data,          64'h0000_0000_0000_CCBB);
    chk("fwd_no_ret", 64'(ram_wr_en),   64'd0);
    rd_addr  = 64'h204;
    ram_data = 64'h1111_1111_1111_1111;
    settle();
    chk("fwd_same_word", rd_data, 64'h1111_1111_1111_CCBB);
    rd_addr = 64'h208;
    settle();
    chk("fwd_other_word", rd_data, 64'h1111_1111_1111_1111);
    rd_en = 1'b0;
    tick();
    tick();
    settle();
    chk("fwd_drained", 64'(buf_empty), 64'd1);

    // Same-cycle store and load: load sees RAM, next load sees the store
    rd_en    = 1'b1;
    rd_addr  = 64'h300;
    ram_data = 64'hDEAD_BEEF_0BAD_F00D;
    store(64'h300, 64'h5555_6666_7777_8888, 8'hFF);
    settle();
    chk("conc_ram", rd_data, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    wr_en = 1'b0;
    settle();
    chk("conc_fwd", rd_data, 64'h5555_6666_7777_8888);
    rd_en = 1'b0;
    tick();
    settle();
    chk("conc_drained", 64'(buf_empty), 64'd1);

    // Flush with 3 entries buffered
    rd_en   = 1'b1;
    rd_addr = 64'h3000;
    for (int i = 0; i < 3; i++) begin
      store(64'h400 + 64'(i * 8), 64'hF0 + 64'(i), 8'h0F);
      tick();
    end
    store(64'h500, 64'hEE, 8'hFF);
    rd_en = 1'b0;
    flush = 1'b1;
    settle();
    chk("fl_rdy", 64'(wr_rdy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fl_ret_en",   64'(ram_wr_en),   64'd1);
      chk("fl_ret_addr", ram_wr_addr,      64'h400 + 64'(i * 8));
      chk("fl_ret_mask", 64'(ram_wr_mask), 64'h0F);
      tick();
      settle();
    end
    chk("fl_empty",     64'(buf_empty), 64'd1);
    chk("fl_idle",      64'(ram_wr_en), 64'd0);
    chk("fl_rdy_held",  64'(wr_rdy),    64'd0);
    flush = 1'b0;
    wr_en = 1'b0;
    settle();
    chk("fl_rdy_back", 64'(wr_rdy), 64'd1);

    // Zero-mask store occupies an entry and retires with mask 0
    store(64'h600, 64'h77, 8'h00);
    tick();
    wr_en = 1'b0;
    settle();
    chk("zm_en",   64'(ram_wr_en),   64'd1);
    chk("zm_mask", 64'(ram_wr_mask), 64'h00);
    tick();
    settle();
    chk("zm_empty", 64'(buf_empty), 64'd1);

    // Reset mid-operation with 2 entries buffered
    rd_en = 1'b1;
    store(64'h700, 64'h1, 8'hFF);
    tick();
    store(64'h708, 64'h2, 8'hFF);
    tick();
    wr_en = 1'b0;
    rd_addr = 64'h700;
    settle();
    chk("rs_pre_busy", 64'(buf_empty), 64'd0);
    rd_en = 1'b0;
    rst   = 1'b1;
    settle();
    chk("rs_cycle_no_wr", 64'(ram_wr_en), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rs_empty", 64'(buf_empty), 64'd1);
    chk("rs_no_wr", 64'(ram_wr_en), 64'd0);
`ifdef STORE_BUF_PERF_EN
    chk("rs_perf_full", 64'(perf_full), 64'd0);
    chk("rs_perf_fwd",  64'(perf_fwd),  64'd0);
`endif
    tick();
    settle();
    chk("rs_still_no_wr", 64'(ram_wr_en), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buf.md
# store_buf

Store buffer between the CPU data-write port and the RAM write port. It accepts CPU stores in one cycle and retires them to RAM in order. RAM is built as a single-port memory, so the buffer retires only in cycles where the CPU is not reading. CPU reads pass straight through to RAM, and buffered bytes are merged into the returned data so the CPU never reads stale memory.

## Interface
Widths come from the global `ADDR_WIDTH and `DATA_WIDTH defines. LANES = `DATA_WIDTH/8. OFS = log2(LANES).

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- i_sys_clk  in  1  system clock; the only clock in the block.
- i_sys_rst  in  1  reset; synchronous, active-high.
- i_cpu_wr_en  in  1  CPU store request.
- i_cpu_wr_addr  in  `ADDR_WIDTH  store byte address.
- i_cpu_wr_data  in  `DATA_WIDTH  store data.
- i_cpu_wr_mask  in  LANES  byte-lane enables.
- o_cpu_wr_rdy  out  1  buffer can accept a store this cycle.
- i_cpu_rd_en  in  1  CPU load request.
- i_cpu_rd_addr  in  `ADDR_WIDTH  load address.
- o_cpu_rd_data  out  `DATA_WIDTH  load data, with buffered bytes merged in.
- o_ram_rd_en  out  1  RAM read enable.
- o_ram_rd_addr  out  `ADDR_WIDTH  RAM read address.
- i_ram_rd_data  in  `DATA_WIDTH  RAM read data; combinational, same cycle.
- o_ram_wr_en  out  1  RAM write enable (retire).
- o_ram_wr_addr  out  `ADDR_WIDTH  retire address.
- o_ram_wr_data  out  `DATA_WIDTH  retire data.
- o_ram_wr_mask  out  LANES  retire byte mask.
- i_flush  in  1  request to drain the buffer; blocks new stores while high.
- o_buf_empty  out  1  no valid entries.

## Operation
- Circular FIFO of DEPTH entries. Each entry holds {addr, data, mask}.
- Control state: wr_ptr, rd_ptr (log2 DEPTH bits, wrap naturally) and count (0..DEPTH).
- Enqueue occurs when i_cpu_wr_en && o_cpu_wr_rdy.
- o_cpu_wr_rdy = (count != DEPTH) && !i_flush.
- Retire: o_ram_wr_en = (count != 0) && !i_cpu_rd_en. The wr address, data and mask come from the head entry. rd_ptr advances on retire.
- RAM read and RAM write are never asserted in the same cycle.
- Simultaneous enqueue and retire: count is unchanged and both pointers advance. This is legal even when count == DEPTH-1 or count == 1.
- Retire order equals accept order. Same-address entries are kept separately and retired in order; they are never coalesced.
- Read path: o_ram_rd_en = i_cpu_rd_en and o_ram_rd_addr = i_cpu_rd_addr (pass-through).
- Forwarding, per byte lane b:
  - Search valid entries with word-address match (addr[`ADDR_WIDTH-1:OFS] equal) and mask[b] set.
  - If any match, the lane takes the newest matching entry's byte. Otherwise it takes i_ram_rd_data's byte.
- A store accepted in the same cycle as a load is not forwarded to that load. It becomes visible from the next cycle.
- i_flush: stops accepting stores. Retire continues under the normal rule. The CPU holds i_flush until o_buf_empty = 1.
- Masks of all zeros are accepted, occupy an entry, and are retired with o_ram_wr_mask = 0.

## Timing
- Reset values: count = 0, pointers = 0, o_buf_empty = 1, o_cpu_wr_rdy = !i_flush, o_ram_wr_en = 0. Entry contents are don't-care; outputs derived from them are qualified by count.
- A store accepted at edge N can appear on o_ram_wr_en no earlier than cycle N+1. There is no empty-buffer bypass.
- o_cpu_rd_data is combinational from i_cpu_rd_addr, i_ram_rd_data and the flopped entries (zero-cycle load latency).
- o_cpu_wr_rdy and o_ram_wr_en are combinational from flops plus i_flush / i_cpu_rd_en. There is no path from i_cpu_wr_en to o_cpu_wr_rdy.
- Continuous loads starve retire indefinitely. This is intended.
- Reset asserted mid-operation: all buffered stores are discarded, with no RAM write in or after the reset cycle.

## Configuration
- STORE_BUF_PERF_EN defined:
  - Adds o_perf_full_cnt (32 bits): counts cycles with i_cpu_wr_en && !o_cpu_wr_rdy.
  - Adds o_perf_fwd_cnt (32 bits): counts loads with at least one lane forwarded.
  - Both counters reset to 0 and wrap at 2^32.
- STORE_BUF_PERF_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
Bench configuration: `ADDR_WIDTH = 64, `DATA_WIDTH = 64, DEPTH = 4.
- Basic store: store 0x1122334455667788 to address 0x80000000 with mask 0xFF and no loads. Required: o_ram_wr_en pulses exactly one cycle later with the same address, data and mask, then o_buf_empty = 1.
- Back-pressure: hold i_cpu_rd_en = 1 and issue 5 stores. Required: the first 4 are accepted, o_cpu_wr_rdy = 0 on the 5th, and o_ram_wr_en stays 0. After loads drop, 4 retires occur in order on consecutive cycles.
- Byte-merge forwarding:
  - RAM word = 0, with i_cpu_rd_en held high through the store/store/load sequence so neither store retires.
  - Store 0xAA to lane 0 (mask 0x01), then 0xBB to lane 0 and 0xCC to lane 1 (mask 0x03).
  - Load the same word. Required: o_cpu_rd_data = 0x000000000000CCBB.
- Concurrent same-cycle store and load to the same address. Required: the load returns RAM data; the next-cycle load returns the forwarded data.
- Flush: with 3 entries buffered, assert i_flush. Required: o_cpu_wr_rdy = 0 and 3 retires follow. Then o_buf_empty = 1 and rdy returns when i_flush drops.
- Reset mid-operation: assert i_sys_rst with 2 entries buffered. Required: no further o_ram_wr_en and o_buf_empty = 1 after the edge. With STORE_BUF_PERF_EN defined, both counters read 0.
